// File: rtl/pn_pkg.sv
// Shared definitions for the Polish Notation stack sequencer: opcodes, FSM states, token layout.
package pn_pkg;

  localparam int unsigned DW_DEFAULT    = 32;
  localparam int unsigned DEPTH_DEFAULT = 16;
  localparam int unsigned OPW           = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_MUL = 3'd2;
  localparam logic [OPW-1:0] OP_ABS = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic           is_op;
    logic [OPW-1:0] val;
  } token_t;

endpackage

// File: rtl/pn_alu.sv
// Shared combinational ALU; all results wrap mod 2^DW, opcodes above OP_ABS are flagged illegal.
module pn_alu
  import pn_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  l,
  input  logic [DW-1:0]  r,
  output logic [DW-1:0]  y_c,
  output logic           illegal_c
);

  logic [DW-1:0] sum;

  always_comb begin
    sum       = l + r;
    y_c       = '0;
    illegal_c = 1'b0;
    case (op)
      OP_ADD:  y_c = sum;
      OP_SUB:  y_c = l - r;
      OP_MUL:  y_c = l * r;
      // Negating the most negative value wraps back to itself
      OP_ABS:  y_c = sum[DW-1] ? -sum : sum;
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/pn_stack_sequencer.sv
// Buffers one token burst, then evaluates it one token per cycle on an operand stack
// through a single shared ALU, emitting a one-cycle result or error strobe.
module pn_stack_sequencer
  import pn_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic           operator,
  input  logic [OPW-1:0] in,
  input  logic           in_valid,
  output logic           busy,
  output logic           out_valid,
  output logic           err,
  output logic [DW-1:0]  out
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d, pos_q, pos_d, sp_q, sp_d;
  logic          mode_q, mode_d, ovf_q, ovf_d;
  logic          busy_d, out_valid_d, err_d;
  logic [DW-1:0] out_d;

  token_t        tok_buf [DEPTH];
  logic [DW-1:0] stack   [DEPTH];

  logic          tok_we, push_we, bad;
  logic [AW-1:0] tok_widx;
  logic [CW-1:0] push_idx, scan_idx, last_pos;
  logic [DW-1:0] push_val, top_v, nxt_v, alu_l, alu_r, alu_y_c;
  logic          alu_illegal_c;
  token_t        cur_tok;

  // Postfix walks the buffer forward, prefix walks it backward
  assign last_pos = count_q - CW'(1);
  assign scan_idx = mode_q ? pos_q : (last_pos - pos_q);
  assign cur_tok  = tok_buf[AW'(scan_idx)];

  assign top_v = stack[AW'(sp_q - CW'(1))];
  assign nxt_v = stack[AW'(sp_q - CW'(2))];
  assign alu_l = mode_q ? nxt_v : top_v;
  assign alu_r = mode_q ? top_v : nxt_v;

  pn_alu #(.DW(DW)) u_alu (
    .op        (cur_tok.val),
    .l         (alu_l),
    .r         (alu_r),
    .y_c       (alu_y_c),
    .illegal_c (alu_illegal_c)
  );

  // Next-state, datapath strobes and registered-output next values
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pos_d    = pos_q;
    sp_d     = sp_q;
    mode_d   = mode_q;
    ovf_d    = ovf_q;
    tok_we   = 1'b0;
    tok_widx = AW'(count_q);
    push_we  = 1'b0;
    push_idx = sp_q;
    push_val = DW'(cur_tok.val);
    bad      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          tok_we   = 1'b1;
          tok_widx = '0;
          count_d  = CW'(1);
          mode_d   = mode;
          ovf_d    = 1'b0;
          pos_d    = '0;
          sp_d     = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (count_q < CW'(DEPTH)) begin
            tok_we  = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d = ovf_q ? ST_ERR : ST_EVAL;
        end
      end
      ST_EVAL: begin
        pos_d = pos_q + CW'(1);
        if (cur_tok.is_op) begin
          if ((sp_q < CW'(2)) || alu_illegal_c) begin
            bad = 1'b1;
          end else begin
            push_we  = 1'b1;
            push_idx = sp_q - CW'(2);
            push_val = alu_y_c;
            sp_d     = sp_q - CW'(1);
          end
        end else begin
          push_we = 1'b1;
          sp_d    = sp_q + CW'(1);
        end
        if (bad) begin
          state_d = ST_ERR;
        end else if (pos_q == last_pos) begin
          state_d = (sp_d == CW'(1)) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
        count_d = '0;
        pos_d   = '0;
        sp_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_EVAL) || (state_d == ST_DONE) || (state_d == ST_ERR);
    out_valid_d = (state_d == ST_DONE) || (state_d == ST_ERR);
    err_d       = (state_d == ST_ERR);
    // Entering DONE means the final push landed at stack[0]
    out_d       = (state_d == ST_DONE) ? push_val : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pos_q     <= '0;
      sp_q      <= '0;
      mode_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      out       <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pos_q     <= pos_d;
      sp_q      <= sp_d;
      mode_q    <= mode_d;
      ovf_q     <= ovf_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
      err       <= err_d;
      out       <= out_d;
    end
  end

  // Token buffer and operand stack storage
  always_ff @(posedge clk) begin
    if (tok_we) begin
      tok_buf[tok_widx] <= '{is_op: operator, val: in};
    end
    if (push_we) begin
      stack[AW'(push_idx)] <= push_val;
    end
  end

endmodule

// File: tb/tb_pn_stack_sequencer.sv
// Randomized self-checking bench for pn_stack_sequencer against a queue-based expression model.
module tb_pn_stack_sequencer;

  typedef logic [3:0] tok_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mode = 1'b0;
  logic        op_flag = 1'b0;
  logic [2:0]  tok_in = 3'd0;
  logic        in_valid = 1'b0;
  logic        busy, out_valid, err;
  logic [31:0] res;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          exp_at = -100;
  int          busy_lo = 1;
  int          busy_hi = 0;
  logic        exp_e = 1'b0;
  logic [31:0] exp_v = 32'd0;
  logic        chk_en = 1'b0;
  logic        ov_w, bz_w;

  pn_stack_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .operator  (op_flag),
    .in        (tok_in),
    .in_valid  (in_valid),
    .busy      (busy),
    .out_valid (out_valid),
    .err       (err),
    .out       (res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Expression semantics: scan order by mode, pop two per operator, early error on underflow/bad opcode
  function automatic void model(input tok_t q[$], input bit m,
                                output logic e, output logic [31:0] v, output int lat);
    logic [31:0] st[$];
    logic [31:0] a, b, l, r, s;
    int n;
    tok_t tk;
    n = q.size();
    e = 1'b1; v = 32'd0;
    if (n > 16) begin
      lat = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      tk = m ? q[k] : q[n-1-k];
      if (tk[3]) begin
        if (st.size() < 2 || tk[2:0] > 3'd3) begin
          lat = k + 2;
          return;
        end
        a = st.pop_back();
        b = st.pop_back();
        l = m ? b : a;
        r = m ? a : b;
        case (tk[1:0])
          2'd0: s = l + r;
          2'd1: s = l - r;
          2'd2: s = l * r;
          default: begin s = l + r; if ($signed(s) < 0) s = -s; end
        endcase
        st.push_back(s);
      end else begin
        st.push_back({29'd0, tk[2:0]});
      end
    end
    lat = n + 1;
    if (st.size() == 1) begin
      e = 1'b0;
      v = st[0];
    end
  endfunction

  // Per-cycle comparison of every output against the current expectation window
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_out", res, 32'd0);
      end else begin
        ov_w = (cyc == exp_at);
        bz_w = (cyc >= busy_lo) && (cyc <= busy_hi);
        chk("busy", {31'd0, busy}, {31'd0, bz_w});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ov_w});
        chk("err", {31'd0, err}, {31'd0, ov_w & exp_e});
        chk("out", res, ov_w ? exp_v : 32'd0);
      end
    end
  end

  task automatic push_burst(input tok_t q[$], input bit m, output int t);
    logic e;
    logic [31:0] v;
    int lat;
    model(q, m, e, v, lat);
    foreach (q[i]) begin
      in_valid = 1'b1;
      op_flag  = q[i][3];
      tok_in   = q[i][2:0];
      mode     = (i == 0) ? m : 1'($urandom);
      @(posedge clk); #1;
    end
    t        = cyc;
    in_valid = 1'b0;
    exp_e    = e;
    exp_v    = v;
    exp_at   = t + lat;
    busy_lo  = t + 1;
    busy_hi  = t + lat;
  endtask

  // junk: 0 quiet, 1 random strobes, 2 strobe every ignored cycle
  task automatic finish_burst(input int junk);
    @(posedge clk); #1;
    while (cyc < exp_at + 1) begin
      in_valid = (junk == 2) ? 1'b1 : (junk == 1) ? 1'($urandom) : 1'b0;
      op_flag  = 1'($urandom);
      tok_in   = 3'($urandom);
      mode     = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input tok_t q[$], input bit m, input int junk);
    int t;
    push_burst(q, m, t);
    finish_burst(junk);
  endtask

  task automatic pin(input string name, input tok_t q[$], input bit m,
                     input logic want_e, input logic [31:0] want_v, input int want_lat);
    logic e;
    logic [31:0] v;
    int lat;
    model(q, m, e, v, lat);
    chk({name, "_err"}, {31'd0, e}, {31'd0, want_e});
    chk({name, "_val"}, v, want_v);
    chk({name, "_lat"}, 32'(lat), 32'(want_lat));
  endtask

  function automatic void gen_valid(output tok_t q[$]);
    int left, ops, d;
    left = $urandom_range(1, 8);
    ops  = left - 1;
    d    = 0;
    q    = {};
    while (left > 0 || ops > 0) begin
      if (left > 0 && (d < 2 || ops == 0 || $urandom_range(0, 1) == 1)) begin
        q.push_back({1'b0, 3'($urandom)});
        d++; left--;
      end else begin
        q.push_back({2'b10, 2'($urandom)});
        d--; ops--;
      end
    end
  endfunction

  initial begin
    tok_t q[$];
    tok_t rq[$];
    int t, kind, len;
    bit m;

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out", res, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-derived results pin the model
    pin("m_postfix", '{4'h3, 4'h4, 4'h8, 4'h2, 4'hA}, 1'b1, 1'b0, 32'd14, 6);
    pin("m_prefix_sub", '{4'h9, 4'h1, 4'hA, 4'h2, 4'h3}, 1'b0, 1'b0, 32'hFFFF_FFFB, 6);
    pin("m_prefix_abs", '{4'hB, 4'h9, 4'h1, 4'h7, 4'h0}, 1'b0, 1'b0, 32'd6, 6);
    pin("m_underflow", '{4'h1, 4'h8}, 1'b1, 1'b1, 32'd0, 3);
    pin("m_mul", '{4'h2, 4'h2, 4'hA}, 1'b1, 1'b0, 32'd4, 4);
    pin("m_badop", '{4'h2, 4'h2, 4'hC}, 1'b1, 1'b1, 32'd0, 4);

    send('{4'h3, 4'h4, 4'h8, 4'h2, 4'hA}, 1'b1, 0);
    send('{4'h9, 4'h1, 4'hA, 4'h2, 4'h3}, 1'b0, 1);
    send('{4'hB, 4'h9, 4'h1, 4'h7, 4'h0}, 1'b0, 2);
    send('{4'h1, 4'h8}, 1'b1, 0);
    send('{4'h2, 4'h2, 4'hA}, 1'b1, 0);

    q = {};
    repeat (17) q.push_back(4'h1);
    pin("m_overflow", q, 1'b1, 1'b1, 32'd0, 1);
    send(q, 1'b1, 2);
    repeat (3) begin @(posedge clk); #1; end

    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      m    = 1'($urandom);
      q    = {};
      if (kind <= 5) begin
        gen_valid(rq);
        if (m) q = rq;
        else foreach (rq[i]) q.push_front(rq[i]);
      end else begin
        len = (kind == 9) ? $urandom_range(17, 20) : $urandom_range(1, 16);
        repeat (len) q.push_back(4'($urandom));
      end
      send(q, m, $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Asynchronous reset in the middle of evaluation
    push_burst('{4'h1, 4'h2, 4'h8, 4'h3, 4'h8, 4'h4, 4'h8, 4'h5, 4'h8}, 1'b1, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n   = 1'b0;
    exp_at  = -100;
    busy_lo = 1;
    busy_hi = 0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_err", {31'd0, err}, 32'd0);
    chk("midreset_out", res, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pin("m_single", '{4'h5}, 1'b1, 1'b0, 32'd5, 2);
    send('{4'h5}, 1'b1, 0);
    repeat (3) begin @(posedge clk); #1; end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
